enigma_host: RTL and testbench

ENIGMA_HOST -- requirements
Module: enigma_host

---
 rtl/enigma_host_pkg.sv | 19 +
 rtl/enigma_host_fifo.sv | 41 ++++
 rtl/enigma_host.sv | 121 ++++++++++++
 tb/tb_enigma_host.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_host_pkg.sv
// Shared definitions for the enigma host controller: state encoding and sizing.
package enigma_host_pkg;
    localparam int TABLE_SIZE = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int SYM_W      = 6;
    localparam int IDX_W      = 8;
    localparam int TIDX_W     = $clog2(TABLE_SIZE);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOAD,
        ST_FIN,
        ST_SETTLE,
        ST_RUN
    } state_t;
endpackage

// File: rtl/enigma_host_fifo.sv
// Small synchronous ciphertext FIFO; head is always visible, count drives the credit check.
module enigma_host_fifo
    import enigma_host_pkg::*;
(
    input  logic             clk,
    input  logic             srstn,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic [SYM_W-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [SYM_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/enigma_host.sv
// Host sequencer for the enigma core: streams the rotor-A table in, then runs
// plaintext through the core with credit-based flow control into a small FIFO.
//
// state  | meaning
// IDLE   | waiting for table entry 0, samples crypt mode
// PRE    | one dead cycle, core ignores the IDLE-cycle write
// LOAD   | accepting entries 1..63
// FIN    | load held one more cycle so entry 63 lands
// SETTLE | core moves LOAD->READY
// RUN    | plaintext accepted under credit limit, terminal until reset
module enigma_host
    import enigma_host_pkg::*;
(
    input  logic             clk,
    input  logic             srstn,
    input  logic             mode,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SYM_W-1:0] cfg_data,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [SYM_W-1:0] pt_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [SYM_W-1:0] ct_data,
    output logic             load,
    output logic [IDX_W-1:0] load_idx,
    output logic [SYM_W-1:0] code_in,
    output logic             encrypt,
    output logic             crypt_mode,
    input  logic [SYM_W-1:0] code_out,
    input  logic             code_valid
);
    state_t              state, state_nxt;
    logic [TIDX_W-1:0]   idx, idx_nxt;
    logic                load_nxt;
    logic [SYM_W-1:0]    code_nxt;
    logic                encrypt_nxt;
    logic                mode_nxt;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      credits;

    assign load_idx = {{(IDX_W-TIDX_W){1'b0}}, idx};
    assign ct_valid = (fifo_count != '0);

    // Symbols already inside the core count against FIFO space.
    assign credits = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(encrypt) + (CNT_W+1)'(code_valid);

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        load_nxt    = load;
        code_nxt    = code_in;
        encrypt_nxt = 1'b0;
        mode_nxt    = crypt_mode;
        cfg_ready   = 1'b0;
        pt_ready    = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    code_nxt  = cfg_data;
                    idx_nxt   = '0;
                    load_nxt  = 1'b1;
                    mode_nxt  = mode;
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: state_nxt = ST_LOAD;
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    idx_nxt  = idx + TIDX_W'(1);
                    code_nxt = cfg_data;
                    if (idx == TIDX_W'(TABLE_SIZE - 2)) state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                load_nxt  = 1'b0;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: state_nxt = ST_RUN;
            ST_RUN: begin
                pt_ready = (credits < (CNT_W+1)'(FIFO_DEPTH));
                if (pt_valid && pt_ready) begin
                    encrypt_nxt = 1'b1;
                    code_nxt    = pt_data;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            load       <= 1'b0;
            code_in    <= '0;
            encrypt    <= 1'b0;
            crypt_mode <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            load       <= load_nxt;
            code_in    <= code_nxt;
            encrypt    <= encrypt_nxt;
            crypt_mode <= mode_nxt;
        end
    end

    enigma_host_fifo u_fifo (
        .clk       (clk),
        .srstn     (srstn),
        .push      (code_valid),
        .push_data (code_out),
        .pop       (ct_valid && ct_ready),
        .head      (ct_data),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_enigma_host.sv
// Directed bench for enigma_host with a behavioural enigma core model
// (rotor position starts at 63 and advances by 2 per symbol).
module tb_enigma_host;
    logic       clk = 1'b0;
    logic       srstn;
    logic       mode;
    logic       cfg_valid, cfg_ready;
    logic [5:0] cfg_data;
    logic       pt_valid, pt_ready;
    logic [5:0] pt_data;
    logic       ct_valid, ct_ready;
    logic [5:0] ct_data;
    logic       load;
    logic [7:0] load_idx;
    logic [5:0] code_in;
    logic       encrypt, crypt_mode;
    logic [5:0] code_out;
    logic       code_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_rx   = 0;
    int sb_pos = 63;
    int sb[$];
    logic [5:0] cur_tbl [64];
    logic [5:0] tbl2    [64];
    logic [5:0] core_tbl[64];
    logic [5:0] core_pos;

    always #5 clk = ~clk;

    enigma_host dut (
        .clk        (clk),
        .srstn      (srstn),
        .mode       (mode),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .pt_data    (pt_data),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .ct_data    (ct_data),
        .load       (load),
        .load_idx   (load_idx),
        .code_in    (code_in),
        .encrypt    (encrypt),
        .crypt_mode (crypt_mode),
        .code_out   (code_out),
        .code_valid (code_valid)
    );

    // Enigma core stand-in: table writes while load, result one cycle after encrypt.
    always @(posedge clk) begin
        if (!srstn) begin
            core_pos   <= 6'd63;
            code_valid <= 1'b0;
            code_out   <= 6'd0;
            for (int i = 0; i < 64; i++) core_tbl[i] <= 6'd0;
        end else begin
            if (load) core_tbl[load_idx[5:0]] <= code_in;
            code_valid <= encrypt;
            if (encrypt) begin
                code_out <= core_tbl[6'(code_in + core_pos)];
                core_pos <= core_pos + 6'd2;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the ct sink checked against the scoreboard.
    task automatic step();
        bit pa, ca;
        pa = pt_valid && pt_ready;
        ca = ct_valid && ct_ready;
        if (ca) begin
            if (sb.size() == 0) chk("ct_unexpected", 1, 0);
            else begin
                chk("ct_data_sb", ct_data, sb.pop_front());
                n_rx++;
            end
        end
        if (pa) begin
            sb.push_back(int'(cur_tbl[(int'(pt_data) + sb_pos) % 64]));
            sb_pos = (sb_pos + 2) % 64;
            n_acc++;
        end
        tick();
    endtask

    task automatic do_reset();
        srstn = 1'b0;
        tick();
        tick();
        srstn = 1'b1;
        sb_pos = 63;
        sb.delete();
        tick();
    endtask

    task automatic load_table(input bit toggle, input int abort_at, input bit chk_idx,
                              output int t);
        int n;
        bit acc, mode0;
        n = 0;
        t = 0;
        mode0 = mode;
        while (n < 64 && t < 400) begin
            if (abort_at >= 0 && n == abort_at) break;
            cfg_valid = toggle ? (t % 2 == 0) : 1'b1;
            cfg_data  = cur_tbl[n];
            acc = cfg_valid && cfg_ready;
            tick();
            t++;
            if (acc) begin
                n++;
                if (n == 1) mode = ~mode0;
            end
            if (chk_idx && n > 0) begin
                chk("load_idx", load_idx, n - 1);
                chk("load_high", load, 1);
            end
        end
        cfg_valid = 1'b0;
        if (abort_at < 0) chk("load_done", n, 64);
    endtask

    task automatic check_table();
        int m = 0;
        for (int i = 0; i < 64; i++) if (core_tbl[i] !== cur_tbl[i]) m++;
        chk("core_table", m, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_load", load, 0);
        chk("rst_load_idx", load_idx, 0);
        chk("rst_code_in", code_in, 0);
        chk("rst_encrypt", encrypt, 0);
        chk("rst_crypt_mode", crypt_mode, 0);
        chk("rst_ct_valid", ct_valid, 0);
        chk("rst_pt_ready", pt_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 64; i++) begin
            cur_tbl[i] = 6'(i);
            tbl2[i]    = 6'((i * 5 + 7) % 64);
        end
        srstn = 1'b0; mode = 1'b0;
        cfg_valid = 1'b0; cfg_data = 6'd0;
        pt_valid = 1'b0; pt_data = 6'd0; ct_ready = 1'b0;
        tick();
        do_reset();
        check_reset_outputs();

        // identity table back-to-back: RUN reached 67 cycles after entry 0
        load_table(1'b0, -1, 1'b1, t);
        chk("fin_cycle", t, 65);
        chk("fin_load_idx", load_idx, 63);
        chk("fin_cfg_ready", cfg_ready, 0);
        tick();
        chk("settle_load", load, 0);
        chk("settle_pt_ready", pt_ready, 0);
        tick();
        chk("run_pt_ready_c67", pt_ready, 1);
        chk("run_cfg_ready", cfg_ready, 0);
        chk("crypt_mode_enc", crypt_mode, 0);
        check_table();

        // pt 0,0 -> ct 63 then 1, three cycles after each accept
        ct_ready = 1'b1; pt_valid = 1'b1; pt_data = 6'd0;
        step();
        chk("encrypt_t1", encrypt, 1);
        chk("code_in_t1", code_in, 0);
        step();
        pt_valid = 1'b0;
        chk("ct_valid_t2", ct_valid, 0);
        step();
        chk("ct_valid_t3", ct_valid, 1);
        chk("ct_first", ct_data, 63);
        chk("encrypt_idle", encrypt, 0);
        step();
        chk("ct_valid_t4", ct_valid, 1);
        chk("ct_second", ct_data, 1);
        step();
        chk("ct_valid_t5", ct_valid, 0);

        // backpressure: exactly four credits
        ct_ready = 1'b0; pt_valid = 1'b1; n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            pt_data = 6'(10 + n_acc);
            step();
        end
        pt_valid = 1'b0;
        chk("bp_accepts", n_acc, 4);
        chk("bp_pt_ready", pt_ready, 0);
        chk("bp_ct_valid", ct_valid, 1);
        chk("bp_head", ct_data, 13);
        ct_ready = 1'b1; n_rx = 0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_drained", n_rx, 4);

        // streaming: one symbol per cycle
        n_acc = 0; n_rx = 0; t = 0; pt_valid = 1'b1;
        while (n_acc < 20 && t < 60) begin
            pt_data = 6'((n_acc * 7) % 64);
            step();
            t++;
        end
        pt_valid = 1'b0;
        chk("stream_cycles", t, 20);
        for (int i = 0; i < 3; i++) step();
        chk("stream_rx", n_rx, 20);
        chk("stream_empty", ct_valid, 0);

        // reset mid-load at entry 30, then toggled reload of a new table in decrypt mode
        do_reset();
        mode = 1'b1;
        load_table(1'b0, 30, 1'b0, t);
        chk("abort_crypt_mode", crypt_mode, 1);
        srstn = 1'b0;
        tick();
        check_reset_outputs();
        srstn = 1'b1;
        sb_pos = 63;
        sb.delete();
        tick();
        chk("rel_cfg_ready", cfg_ready, 1);
        chk("rel_pt_ready", pt_ready, 0);
        for (int i = 0; i < 64; i++) cur_tbl[i] = tbl2[i];
        mode = 1'b1;
        load_table(1'b1, -1, 1'b1, t);
        chk("reload_crypt_mode", crypt_mode, 1);
        tick();
        tick();
        chk("reload_run", pt_ready, 1);
        check_table();
        pt_valid = 1'b1; pt_data = 6'd0;
        step();
        pt_valid = 1'b0;
        step();
        step();
        chk("reload_ct_valid", ct_valid, 1);
        chk("reload_ct", ct_data, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
